// File: rtl/seven_seg_scan.sv
// Time-multiplexed seven-segment scanner with a double-buffered frame,
// per-digit blanking and commit of new data only at frame boundaries.
module seven_seg_scan #(
    parameter int unsigned NUM_DIGITS     = 4,
    parameter int unsigned SEG_W          = 7,
    parameter int unsigned PERIOD         = 40000,
    parameter int unsigned CBITS          = 16,
    parameter bit          SEG_ACTIVE_LOW = 1'b0,
    parameter bit          AN_ACTIVE_LOW  = 1'b0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_DIGITS*SEG_W-1:0]   seg_data,
    input  logic                          load,
    input  logic [NUM_DIGITS-1:0]         blank_mask,
    output logic [SEG_W-1:0]              segment,
    output logic [NUM_DIGITS-1:0]         digit_en,
    output logic                          tick,
    output logic                          frame_start,
    output logic                          update_pending
);

    localparam int unsigned IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned FRAME_W = NUM_DIGITS * SEG_W;

    localparam logic [CBITS-1:0]      CNT_LAST = CBITS'(PERIOD - 1);
    localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [SEG_W-1:0]      SEG_OFF  = {SEG_W{SEG_ACTIVE_LOW}};
    localparam logic [NUM_DIGITS-1:0] AN_OFF   = {NUM_DIGITS{AN_ACTIVE_LOW}};

    logic [CBITS-1:0]      r_cnt;
    logic [IDX_W-1:0]      r_idx;
    logic [FRAME_W-1:0]    r_shadow;
    logic [FRAME_W-1:0]    r_active;

    logic                  w_slot_end;
    logic                  w_boundary;
    logic                  w_commit;
    logic [IDX_W-1:0]      w_idx_next;
    logic [FRAME_W-1:0]    w_frame;
    logic [SEG_W-1:0]      w_digits [NUM_DIGITS];
    logic [SEG_W-1:0]      w_pattern;
    logic                  w_blank;
    logic [NUM_DIGITS-1:0] w_onehot;

    // Frame currently on display, including a commit happening this very edge
    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_unpack
        assign w_digits[k] = w_frame[k*SEG_W +: SEG_W];
    end

    // Slot sequencing; idx=0 after reset so the first decrement wraps to the top digit
    always_comb begin
        w_slot_end = 1'b0;
        w_boundary = 1'b0;
        w_commit   = 1'b0;
        w_idx_next = r_idx;
        w_frame    = r_active;
        w_pattern  = '0;
        w_blank    = 1'b0;
        w_onehot   = '0;

        w_slot_end = (r_cnt == CNT_LAST);
        w_idx_next = (r_idx == '0) ? IDX_LAST : (r_idx - IDX_W'(1));
        w_boundary = w_slot_end && (r_idx == '0);
        w_commit   = w_boundary && update_pending;
        w_frame    = w_commit ? r_shadow : r_active;
        w_pattern  = w_digits[w_idx_next];
        w_blank    = blank_mask[w_idx_next];
        w_onehot   = NUM_DIGITS'(1) << w_idx_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt          <= '0;
            r_idx          <= '0;
            r_shadow       <= '0;
            r_active       <= '0;
            update_pending <= 1'b0;
            tick           <= 1'b0;
            frame_start    <= 1'b0;
            segment        <= SEG_OFF;
            digit_en       <= AN_OFF;
        end else begin
            tick        <= w_slot_end;
            frame_start <= w_boundary;

            if (w_slot_end) begin
                r_cnt    <= '0;
                r_idx    <= w_idx_next;
                segment  <= (w_blank ? '0 : w_pattern) ^ SEG_OFF;
                digit_en <= (w_blank ? '0 : w_onehot) ^ AN_OFF;
            end else begin
                r_cnt <= r_cnt + CBITS'(1);
            end

            if (w_commit) begin
                r_active <= r_shadow;
            end

            // A load on a boundary edge lands after the commit and keeps pending set
            if (load) begin
                r_shadow       <= seg_data;
                update_pending <= 1'b1;
            end else if (w_commit) begin
                update_pending <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seven_seg_scan.sv
// Scoreboard bench for seven_seg_scan: an edge-indexed reference model queues
// expected events; a monitor checks both polarity variants every cycle.
module tb_seven_seg_scan;

    localparam int unsigned N  = 3;
    localparam int unsigned W  = 7;
    localparam int unsigned P  = 4;
    localparam int unsigned CB = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic           load;
    logic [N*W-1:0] seg_data;
    logic [N-1:0]   blank_mask;

    logic [W-1:0]   seg_a, seg_b;
    logic [N-1:0]   en_a, en_b;
    logic           tick_a, tick_b, fs_a, fs_b, pend_a, pend_b;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    seven_seg_scan #(.NUM_DIGITS(N), .SEG_W(W), .PERIOD(P), .CBITS(CB),
                     .SEG_ACTIVE_LOW(1'b0), .AN_ACTIVE_LOW(1'b0)) u_dut_hi (
        .clk(clk), .rst(rst), .seg_data(seg_data), .load(load), .blank_mask(blank_mask),
        .segment(seg_a), .digit_en(en_a), .tick(tick_a), .frame_start(fs_a),
        .update_pending(pend_a)
    );

    seven_seg_scan #(.NUM_DIGITS(N), .SEG_W(W), .PERIOD(P), .CBITS(CB),
                     .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)) u_dut_lo (
        .clk(clk), .rst(rst), .seg_data(seg_data), .load(load), .blank_mask(blank_mask),
        .segment(seg_b), .digit_en(en_b), .tick(tick_b), .frame_start(fs_b),
        .update_pending(pend_b)
    );

    typedef struct {
        int           edge_n;
        bit           tk;
        bit           fs;
        logic [W-1:0] seg;
        logic [N-1:0] en;
        bit           pend;
    } exp_t;

    exp_t sbq[$];

    // Reference model state: edges since reset release, buffers, held outputs
    int           n_edge = 0;
    int           e      = 0;
    logic [W-1:0] m_shadow [N];
    logic [W-1:0] m_active [N];
    bit           m_pend;
    logic [W-1:0] m_seg;
    logic [N-1:0] m_en;

    function automatic void chk(input string nm, input int cyc,
                                input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", nm, cyc, act, req);
        end
    endfunction

    function automatic bit is_boundary(input int ee);
        return (ee > 0) && (ee % P == 0) && (((ee / P) - 1) % N == 0);
    endfunction

    function automatic int cur_digit();
        if (e < int'(P)) return -1;
        return int'(N) - 1 - (((e / P) - 1) % N);
    endfunction

    // Drive one edge's inputs, predict that edge's outcome, then wait to the falling edge
    task automatic step(input bit r, input bit ld, input logic [N*W-1:0] d, input logic [N-1:0] bm);
        exp_t it;
        bit   ev;
        int   s;
        int   dg;
        rst        = r;
        load       = ld;
        seg_data   = d;
        blank_mask = bm;
        n_edge++;
        ev    = 1'b0;
        it.tk = 1'b0;
        it.fs = 1'b0;
        if (r) begin
            e = 0;
            for (int k = 0; k < N; k++) begin
                m_shadow[k] = '0;
                m_active[k] = '0;
            end
            m_pend = 1'b0;
            m_seg  = '0;
            m_en   = '0;
            ev     = 1'b1;
        end else begin
            e++;
            if (e % P == 0) begin
                s     = e / P;
                dg    = int'(N) - 1 - ((s - 1) % N);
                ev    = 1'b1;
                it.tk = 1'b1;
                it.fs = (dg == int'(N) - 1);
                if (it.fs && m_pend) begin
                    m_active = m_shadow;
                    m_pend   = 1'b0;
                end
                if (bm[dg]) begin
                    m_seg = '0;
                    m_en  = '0;
                end else begin
                    m_seg = m_active[dg];
                    m_en  = N'(1) << dg;
                end
            end
            if (ld) begin
                for (int k = 0; k < N; k++) m_shadow[k] = d[k*W +: W];
                m_pend = 1'b1;
                ev     = 1'b1;
            end
        end
        if (ev) begin
            it.edge_n = n_edge;
            it.seg    = m_seg;
            it.en     = m_en;
            it.pend   = m_pend;
            sbq.push_back(it);
        end
        @(negedge clk);
    endtask

    // Monitor: pops on the edge an event is due, otherwise expects held outputs
    initial begin
        int           m;
        bit           have;
        bit           x_tk, x_fs, x_pend;
        logic [W-1:0] x_seg, x_seg_n;
        logic [N-1:0] x_en, x_en_n;
        exp_t         cur;
        m      = 0;
        have   = 1'b0;
        x_pend = 1'b0;
        x_seg  = '0;
        x_en   = '0;
        forever begin
            @(posedge clk);
            #1;
            m++;
            x_tk = 1'b0;
            x_fs = 1'b0;
            if (sbq.size() > 0 && sbq[0].edge_n == m) begin
                cur    = sbq.pop_front();
                x_tk   = cur.tk;
                x_fs   = cur.fs;
                x_seg  = cur.seg;
                x_en   = cur.en;
                x_pend = cur.pend;
                have   = 1'b1;
            end
            if (have) begin
                x_seg_n = ~x_seg;
                x_en_n  = ~x_en;
                chk("tick",            m, 32'(tick_a), 32'(x_tk));
                chk("frame_start",     m, 32'(fs_a),   32'(x_fs));
                chk("segment",         m, 32'(seg_a),  32'(x_seg));
                chk("digit_en",        m, 32'(en_a),   32'(x_en));
                chk("update_pending",  m, 32'(pend_a), 32'(x_pend));
                chk("tick_inv",        m, 32'(tick_b), 32'(x_tk));
                chk("frame_start_inv", m, 32'(fs_b),   32'(x_fs));
                chk("segment_inv",     m, 32'(seg_b),  32'(x_seg_n));
                chk("digit_en_inv",    m, 32'(en_b),   32'(x_en_n));
                chk("pending_inv",     m, 32'(pend_b), 32'(x_pend));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [N*W-1:0] rd;
        logic [N-1:0]   bmv;
        bmv = '0;

        // Reset and first full scan with an empty frame
        step(1'b1, 1'b0, '0, bmv);
        step(1'b1, 1'b0, '0, bmv);
        repeat (16) step(1'b0, 1'b0, '0, bmv);

        // Load during the middle slot, commit at the next boundary
        while (cur_digit() != 1) step(1'b0, 1'b0, '0, bmv);
        step(1'b0, 1'b1, {7'h3F, 7'h06, 7'h5B}, bmv);
        repeat (3 * N * P) step(1'b0, 1'b0, '0, bmv);

        // Load A, then load B exactly on a boundary edge
        step(1'b0, 1'b1, {7'h11, 7'h22, 7'h33}, bmv);
        while (!is_boundary(e + 1)) step(1'b0, 1'b0, '0, bmv);
        step(1'b0, 1'b1, {7'h44, 7'h55, 7'h66}, bmv);
        repeat (2 * N * P) step(1'b0, 1'b0, '0, bmv);

        // Minimum latency: load on the edge right before a boundary
        while (!is_boundary(e + 2)) step(1'b0, 1'b0, '0, bmv);
        step(1'b0, 1'b1, {7'h7F, 7'h01, 7'h40}, bmv);
        repeat (N * P) step(1'b0, 1'b0, '0, bmv);

        // Blanking the middle digit, then a mid-slot mask change
        bmv = 3'b010;
        repeat (2 * N * P) step(1'b0, 1'b0, '0, bmv);
        while (e % P != 1) step(1'b0, 1'b0, '0, bmv);
        bmv = 3'b101;
        repeat (N * P) step(1'b0, 1'b0, '0, bmv);
        bmv = 3'b000;

        // Reset mid-frame while an update is pending
        while (cur_digit() != 1) step(1'b0, 1'b0, '0, bmv);
        step(1'b0, 1'b1, {7'h0A, 7'h0B, 7'h0C}, bmv);
        step(1'b0, 1'b0, '0, bmv);
        step(1'b1, 1'b0, '0, bmv);
        repeat (2 * N * P) step(1'b0, 1'b0, '0, bmv);

        // Randomised loads, masks and occasional resets
        repeat (400) begin
            rd = (N*W)'($urandom);
            if ($urandom_range(0, 9) == 0) bmv = N'($urandom);
            step(($urandom_range(0, 149) == 0), ($urandom_range(0, 5) == 0), rd, bmv);
        end

        repeat (4) step(1'b0, 1'b0, '0, '0);
        chk("queue_drained", n_edge, 32'(sbq.size()), 32'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seven_seg_scan.md
# seven_seg_scan

Parametrised time-multiplexed driver for a common-segment seven-segment display with NUM_DIGITS digits. It holds a double-buffered frame of segment patterns and scans one digit per refresh period, driving the segment bus and a one-hot digit enable. Per-digit blanking and a frame-synchronous update handshake prevent visible tearing. It sits between the display-formatting logic and the board pins, and replaces the fixed two-digit scanner.

## Interface
- NUM_DIGITS, 4: number of digits scanned; must be ≥ 2.
- SEG_W, 7: segment bits per digit (8 includes the decimal point).
- PERIOD, 40000: clocks per digit slot; must be ≥ 2.
- CBITS, 16: refresh counter width; must hold PERIOD-1.
- SEG_ACTIVE_LOW, 0: 1 inverts `segment` at the output register.
- AN_ACTIVE_LOW, 0: 1 inverts `digit_en` at the output register.

Ports:
- clk  in  1  sole clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- seg_data  in  NUM_DIGITS*SEG_W  frame patterns; digit k occupies [k*SEG_W +: SEG_W].
- load  in  1  one-cycle strobe that captures `seg_data` into the shadow buffer.
- blank_mask  in  NUM_DIGITS  bit k=1 blanks digit k; sampled at each slot change.
- segment  out  SEG_W  registered segment drive.
- digit_en  out  NUM_DIGITS  registered one-hot (or all-inactive) digit enable.
- tick  out  1  one-cycle pulse coincident with each slot change.
- frame_start  out  1  one-cycle pulse when digit NUM_DIGITS-1 becomes active.
- update_pending  out  1  high while the shadow buffer holds data not yet committed.

## Operation
- Reset has full priority and nothing else updates in that cycle.
  - cnt=0, idx=0, shadow=0, active=0, update_pending=0, tick=0, frame_start=0.
  - `segment` and `digit_en` go to their inactive levels: all-0 when active-high, all-1 when inverted.
- Refresh counter:
  - cnt increments each cycle.
  - When cnt==PERIOD-1, the slot changes: cnt←0 and tick←1. On all other cycles tick←0.
- Scan order at each slot change:
  - The first slot after reset selects digit NUM_DIGITS-1.
  - Each later slot decrements idx.
  - After digit 0, the scan wraps to digit NUM_DIGITS-1.
- Frame boundary: any slot change that selects digit NUM_DIGITS-1. At a frame boundary, frame_start←1; on all other cycles frame_start←0.
- Commit at a frame boundary, evaluated before the output pattern is selected:
  - If update_pending=1, then active←shadow and update_pending←0.
  - The newly committed data is displayed from that same slot onward.
- Load:
  - On a load=1 cycle, shadow←seg_data and update_pending←1.
  - A load while pending overwrites the shadow (last write wins). No data is lost to the display except superseded frames.
- Load and frame boundary in the same cycle:
  - The commit uses the old shadow contents.
  - The shadow then takes the new data and update_pending stays 1.
  - The new data commits at the next boundary.
- Output selection at a slot change for digit d:
  - If blank_mask[d]=0: segment←active[d*SEG_W +: SEG_W] and digit_en←one-hot(d).
  - If blank_mask[d]=1: both take their inactive levels.
  - Polarity inversion is applied after selection.
- Between slot changes, `segment` and `digit_en` hold their values. Changes to `blank_mask` or `seg_data` between slot changes have no effect until the next slot change.
- `seg_data` is ignored except on load cycles.

## Timing
- All outputs are registered. There is no combinational path from any input to any output.
- The first slot change occurs on the PERIOD-th rising edge after the first edge at which rst is sampled low. Later slot changes follow every PERIOD cycles exactly.
- tick and frame_start are each high for exactly one cycle.
- A full frame lasts NUM_DIGITS*PERIOD cycles.
- Load-to-display latency:
  - Minimum: 1 cycle, when load occurs on the cycle before a boundary.
  - Maximum: NUM_DIGITS*PERIOD cycles.
- Reset asserted mid-scan takes effect at the next edge and discards any pending update. The scan restarts as from power-up.
- Counter wrap uses equality with PERIOD-1 only. cnt never exceeds PERIOD-1.

## Test plan
All scenarios use NUM_DIGITS=3, SEG_W=7, PERIOD=4, and active-high polarity unless stated otherwise.

- Reset and first scan: release rst with active=0 and no load.
  - segment=0 and digit_en=000 until edge 4.
  - At edge 4: tick=1, frame_start=1, digit_en=100.
  - At edges 8 and 12: digit_en=010, then 001.
  - At edge 16: digit_en=100 with frame_start=1.
- Load commit: load with seg_data={7'h3F,7'h06,7'h5B} during slot 010.
  - update_pending=1 until the next boundary.
  - At that boundary: segment=3F with digit_en=100, then 06, then 5B. update_pending returns to 0.
- Load during frame boundary: load A, then load B exactly on a boundary cycle.
  - That frame displays A.
  - update_pending stays 1.
  - B displays from the following frame.
- Blanking: set blank_mask=010.
  - The middle slot shows segment=0 and digit_en=000.
  - The other slots are unaffected.
  - A blank_mask change mid-slot does not alter outputs until the next tick.
- Polarity: with SEG_ACTIVE_LOW=1 and AN_ACTIVE_LOW=1, reset gives segment=7F and digit_en=111. Digit 2 showing pattern 3F yields segment=40 and digit_en=011.
- Reset mid-frame: assert rst for 1 cycle while update_pending=1 during slot 010.
  - Next cycle: all outputs are at reset values and update_pending=0.
  - The first tick occurs 4 cycles after release and selects digit_en=100.
